reu_dma_seq: RTL and testbench

- DMA transfer sequencer for the REU CPLD.
- Consumes the register block's Execute, XferType, Length1 and bus status.
- Drives the C64 expansion-port DMA/bus cycle and the REU SRAM strobes/data path.
- Returns the per-byte IncCA, IncREUA, DecLen, XferEnd, SetEndOfBlock and SetVerifyErr controls that the register block samples on the same PHI2 falling edge.

---
 rtl/reu_dma_seq.sv | 116 +++++++++++
 tb/tb_reu_dma_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reu_dma_seq.sv
// reu_dma_seq: REU DMA transfer sequencer; runs C64 expansion-port bus cycles and SRAM strobes,
// returning per-byte advance and termination controls sampled by the register block on PHI2 fall.
module reu_dma_seq #(
   parameter int ARM_CYCLES  = 1,
   parameter bit VERIFY_STOP = 1'b1
) (
   input  logic       PHI2,
   input  logic       Reset,
   input  logic       Execute,
   input  logic [1:0] XferType,
   input  logic       Length1,
   input  logic       BA,
   input  logic [7:0] CPUDin,
   input  logic [7:0] RAMDin,
   output logic       DMA,
   output logic       CPURnW,
   output logic       CPUDOE,
   output logic [7:0] CPUDout,
   output logic       RAMOE,
   output logic       RAMWE,
   output logic [7:0] RAMDout,
   output logic       IncCA,
   output logic       IncREUA,
   output logic       DecLen,
   output logic       XferEnd,
   output logic       SetEndOfBlock,
   output logic       SetVerifyErr,
   output logic       Busy
);
   typedef enum logic [2:0] {IDLE, ARM, STASH, FETCH, SWAP_RD, SWAP_WR, VERIFY} state_t;
   state_t      state, stateNext, curState;
   logic [1:0]  xt;
   logic [15:0] armCnt;
   logic [7:0]  latchC, latchR;
   logic        v, byteDone, mismatch, armDone;
   // Outputs see IDLE while Reset is held, so an abort never emits strobes or end flags.
   assign curState      = Reset ? IDLE : state;
   assign v             = BA;
   assign armDone       = armCnt == 16'(ARM_CYCLES - 1);
   assign DMA           = curState != IDLE;
   assign Busy          = curState != IDLE;
   assign IncCA         = byteDone;
   assign IncREUA       = byteDone;
   assign DecLen        = byteDone;
   assign SetEndOfBlock = byteDone & Length1;
   assign SetVerifyErr  = mismatch;
   always_ff @(negedge PHI2) begin
      if (Reset) begin
         state  <= IDLE;
         xt     <= 2'b00;
         armCnt <= '0;
         latchC <= 8'h00;
         latchR <= 8'h00;
      end else begin
         state <= stateNext;
         if (state == IDLE && Execute) begin
            xt     <= XferType;
            armCnt <= '0;
         end
         if (state == ARM && !armDone)
            armCnt <= armCnt + 16'd1;
         if (state == SWAP_RD && v) begin
            latchC <= CPUDin;
            latchR <= RAMDin;
         end
      end
   end
   always_comb begin
      stateNext = state;
      byteDone  = 1'b0;
      mismatch  = 1'b0;
      CPURnW    = 1'b1;
      CPUDOE    = 1'b0;
      CPUDout   = 8'h00;
      RAMOE     = 1'b0;
      RAMWE     = 1'b0;
      RAMDout   = 8'h00;
      case (curState)
         IDLE: if (Execute) stateNext = ARM;
         ARM: if (armDone) stateNext = xt == 2'b00 ? STASH : xt == 2'b01 ? FETCH : xt == 2'b10 ? SWAP_RD : VERIFY;
         STASH: begin
            RAMDout  = CPUDin;
            RAMWE    = PHI2 & v;
            byteDone = v;
         end
         FETCH: begin
            RAMOE    = v;
            CPURnW   = ~v;
            CPUDout  = RAMDin;
            CPUDOE   = PHI2 & v;
            byteDone = v;
         end
         SWAP_RD: begin
            RAMOE = v;
            if (v) stateNext = SWAP_WR;
         end
         SWAP_WR: begin
            CPURnW   = ~v;
            CPUDout  = latchR;
            CPUDOE   = PHI2 & v;
            RAMDout  = latchC;
            RAMWE    = PHI2 & v;
            byteDone = v;
            if (v) stateNext = SWAP_RD;
         end
         VERIFY: begin
            RAMOE    = v;
            byteDone = v;
            mismatch = v & (CPUDin != RAMDin);
         end
         default: stateNext = IDLE;
      endcase
      XferEnd = (byteDone & Length1) | (mismatch & VERIFY_STOP);
      if (XferEnd) stateNext = IDLE;
   end
endmodule

// File: tb/tb_reu_dma_seq.sv
// tb_reu_dma_seq: randomized bench for reu_dma_seq; emulates the register block's length/address
// counters and scores bus writes, strobe counts and flags against a byte-level transfer model.
module tb_reu_dma_seq;
   localparam int ARM_CYCLES  = 1;
   localparam bit VERIFY_STOP = 1'b1;
   logic PHI2 = 1'b0, Reset = 1'b1, Execute = 1'b0, Length1 = 1'b0, BA = 1'b1;
   logic [1:0] XferType = 2'b00;
   logic [7:0] CPUDin = 8'h00, RAMDin = 8'h00;
   logic DMA, CPURnW, CPUDOE, RAMOE, RAMWE, IncCA, IncREUA, DecLen, XferEnd, SetEndOfBlock, SetVerifyErr, Busy;
   logic [7:0] CPUDout, RAMDout;
   reu_dma_seq #(.ARM_CYCLES(ARM_CYCLES), .VERIFY_STOP(VERIFY_STOP)) dut (
      .PHI2(PHI2), .Reset(Reset), .Execute(Execute), .XferType(XferType), .Length1(Length1),
      .BA(BA), .CPUDin(CPUDin), .RAMDin(RAMDin), .DMA(DMA), .CPURnW(CPURnW), .CPUDOE(CPUDOE),
      .CPUDout(CPUDout), .RAMOE(RAMOE), .RAMWE(RAMWE), .RAMDout(RAMDout), .IncCA(IncCA),
      .IncREUA(IncREUA), .DecLen(DecLen), .XferEnd(XferEnd), .SetEndOfBlock(SetEndOfBlock),
      .SetVerifyErr(SetVerifyErr), .Busy(Busy));
   always #5 PHI2 = ~PHI2;
   int tests = 0, fails = 0;
   logic [7:0] cpuData [0:255];
   logic [7:0] ramData [0:255];
   int len, bc;
   logic [7:0] ramW[$], cpuW[$], expRamW[$], expCpuW[$];
   int incs, eobs, verrs, validCnt, viol, endCyc, postDma, postBusy;
   int expIncs, expEob, expVerr, expValid;
   bit done;
   function automatic logic strobes();
      return RAMWE | RAMOE | CPUDOE | IncCA | IncREUA | DecLen | XferEnd | SetEndOfBlock | SetVerifyErr;
   endfunction
   function automatic bit qeq(input logic [7:0] a[$], input logic [7:0] b[$]);
      if (a.size() != b.size()) return 0;
      foreach (a[i]) if (a[i] !== b[i]) return 0;
      return 1;
   endfunction
   task automatic drive(input logic exe, input logic ba);
      Execute = exe;
      BA = ba;
      Length1 = (len == 1);
      CPUDin = cpuData[bc % 256];
      RAMDin = ramData[bc % 256];
   endtask
   // Byte-level view of a transfer: what each side receives and how the block ends.
   task automatic model(input logic [1:0] t, input int n);
      int k = -1, m = 0;
      expRamW.delete();
      expCpuW.delete();
      for (int i = 0; i < n; i++) begin
         if (cpuData[i] != ramData[i]) begin m++; if (k < 0) k = i; end
         if (t == 2'b00 || t == 2'b10) expRamW.push_back(cpuData[i]);
         if (t == 2'b01 || t == 2'b10) expCpuW.push_back(ramData[i]);
      end
      expIncs = n; expEob = 1; expVerr = 0; expValid = (t == 2'b10) ? 2 * n : n;
      if (t == 2'b11) begin
         expVerr = VERIFY_STOP ? int'(k >= 0) : m;
         if (VERIFY_STOP && k >= 0) begin expIncs = k + 1; expValid = k + 1; expEob = int'(k == n - 1); end
      end
   endtask
   task automatic run_xfer(input logic [1:0] t, input int n, input int stallPct, input int stallAt);
      bit dec = 0;
      int cyc = 0;
      len = n; bc = 0; ramW.delete(); cpuW.delete();
      incs = 0; eobs = 0; verrs = 0; validCnt = 0; viol = 0; endCyc = -1; done = 0;
      XferType = t;
      while (!done && cyc < 4000) begin
         @(negedge PHI2);
         if (dec) begin len--; bc++; end
         #1;
         drive(cyc == 0 ? 1'b1 : ($urandom_range(0, 3) == 0),
               (cyc >= stallAt && cyc < stallAt + 2) ? 1'b0 : ($urandom_range(0, 99) >= stallPct));
         @(posedge PHI2); #2;
         dec = DecLen;
         if (cyc == 0) begin
            if (Busy) viol++;
         end else if (cyc <= ARM_CYCLES) begin
            if (!DMA || !Busy || !CPURnW || strobes()) viol++;
         end else begin
            if (!DMA || !Busy) viol++;
            if (!BA && (strobes() || !CPURnW)) viol++;
            if (IncCA !== DecLen || IncREUA !== DecLen) viol++;
            if ((CPUDOE && CPURnW) || (RAMWE && RAMOE) || (SetEndOfBlock && !Length1)) viol++;
            if (BA) validCnt++;
            if (RAMWE) ramW.push_back(RAMDout);
            if (CPUDOE) cpuW.push_back(CPUDout);
            incs += int'(DecLen); eobs += int'(SetEndOfBlock); verrs += int'(SetVerifyErr);
            if (XferEnd) begin done = 1; endCyc = cyc; end
         end
         cyc++;
      end
      @(negedge PHI2);
      if (dec) begin len--; bc++; end
      #1;
      drive(1'b0, 1'b1);
      @(posedge PHI2); #2;
      postDma = int'(DMA); postBusy = int'(Busy);
   endtask
   task automatic test_reset;
      Reset = 1'b1;
      drive(1'b1, 1'b1);
      repeat (2) @(negedge PHI2);
      @(posedge PHI2); #2;
      tests++; if ({DMA, Busy, strobes()} !== 3'b000) begin fails++; $display("FAIL reset_outs got DMA=%b Busy=%b strobes=%b want 000", DMA, Busy, strobes()); end
      tests++; if (CPURnW !== 1'b1) begin fails++; $display("FAIL reset_rnw got %b want 1", CPURnW); end
      @(negedge PHI2); #1;
      Reset = 1'b0;
      drive(1'b0, 1'b1);
      @(posedge PHI2); #2;
      tests++; if ({DMA, Busy, CPURnW} !== 3'b001) begin fails++; $display("FAIL reset_idle got %b want 001", {DMA, Busy, CPURnW}); end
   endtask
   task automatic test_stash;
      cpuData[0] = 8'h11; cpuData[1] = 8'h22; cpuData[2] = 8'h33;
      for (int i = 0; i < 3; i++) ramData[i] = 8'($urandom);
      model(2'b00, 3);
      run_xfer(2'b00, 3, 0, 1000);
      tests++; if (!qeq(ramW, expRamW)) begin fails++; $display("FAIL stash_data got %p want %p", ramW, expRamW); end
      tests++; if (cpuW.size() !== 0) begin fails++; $display("FAIL stash_cpuw got %0d writes want 0", cpuW.size()); end
      tests++; if (incs !== 3 || eobs !== 1) begin fails++; $display("FAIL stash_counts got incs=%0d eob=%0d want 3 1", incs, eobs); end
      tests++; if (endCyc !== ARM_CYCLES + 3) begin fails++; $display("FAIL stash_end got %0d want %0d", endCyc, ARM_CYCLES + 3); end
      tests++; if (postDma !== 0 || postBusy !== 0 || viol !== 0) begin fails++; $display("FAIL stash_clean got dma=%0d busy=%0d viol=%0d want 0 0 0", postDma, postBusy, viol); end
   endtask
   task automatic test_fetch;
      ramData[0] = 8'hA5; ramData[1] = 8'h5A;
      model(2'b01, 2);
      run_xfer(2'b01, 2, 0, 1000);
      tests++; if (!qeq(cpuW, expCpuW)) begin fails++; $display("FAIL fetch_data got %p want %p", cpuW, expCpuW); end
      tests++; if (ramW.size() !== 0 || incs !== 2) begin fails++; $display("FAIL fetch_counts got ramw=%0d incs=%0d want 0 2", ramW.size(), incs); end
      tests++; if (endCyc !== ARM_CYCLES + 2 || viol !== 0) begin fails++; $display("FAIL fetch_end got end=%0d viol=%0d want %0d 0", endCyc, viol, ARM_CYCLES + 2); end
   endtask
   task automatic test_swap;
      cpuData[0] = 8'h12; ramData[0] = 8'h34;
      model(2'b10, 1);
      run_xfer(2'b10, 1, 0, 1000);
      tests++; if (!qeq(ramW, expRamW) || !qeq(cpuW, expCpuW)) begin fails++; $display("FAIL swap_data got ram=%p cpu=%p want %p %p", ramW, cpuW, expRamW, expCpuW); end
      tests++; if (incs !== 1 || validCnt !== 2) begin fails++; $display("FAIL swap_counts got incs=%0d cycles=%0d want 1 2", incs, validCnt); end
      tests++; if (endCyc !== ARM_CYCLES + 2 || viol !== 0) begin fails++; $display("FAIL swap_end got end=%0d viol=%0d want %0d 0", endCyc, viol, ARM_CYCLES + 2); end
   endtask
   task automatic test_verify;
      for (int i = 0; i < 4; i++) begin ramData[i] = 8'($urandom); cpuData[i] = ramData[i]; end
      cpuData[1] = 8'h00; ramData[1] = 8'hFF;
      model(2'b11, 4);
      run_xfer(2'b11, 4, 0, 1000);
      tests++; if (verrs !== 1 || incs !== 2 || eobs !== 0) begin fails++; $display("FAIL verify_flags got verr=%0d incs=%0d eob=%0d want 1 2 0", verrs, incs, eobs); end
      tests++; if (endCyc !== ARM_CYCLES + 2 || postDma !== 0) begin fails++; $display("FAIL verify_end got end=%0d dma=%0d want %0d 0", endCyc, postDma, ARM_CYCLES + 2); end
   endtask
   task automatic test_stall;
      cpuData[0] = 8'hC3; cpuData[1] = 8'h3C;
      model(2'b00, 2);
      run_xfer(2'b00, 2, 0, ARM_CYCLES + 2);
      tests++; if (!qeq(ramW, expRamW) || incs !== 2) begin fails++; $display("FAIL stall_data got %p incs=%0d want %p 2", ramW, incs, expRamW); end
      tests++; if (endCyc !== ARM_CYCLES + 4 || viol !== 0) begin fails++; $display("FAIL stall_end got end=%0d viol=%0d want %0d 0", endCyc, viol, ARM_CYCLES + 4); end
   endtask
   task automatic test_random;
      for (int r = 0; r < 12; r++) begin
         logic [1:0] t = 2'($urandom_range(0, 3));
         int n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) begin
            ramData[i] = 8'($urandom);
            cpuData[i] = (t == 2'b11 && $urandom_range(0, 7) != 0) ? ramData[i] : 8'($urandom);
         end
         model(t, n);
         run_xfer(t, n, 30, 1000);
         tests++; if (!done || !qeq(ramW, expRamW) || !qeq(cpuW, expCpuW)) begin fails++; $display("FAIL rand%0d_data t=%0d n=%0d done=%0d ram=%p cpu=%p want %p %p", r, t, n, done, ramW, cpuW, expRamW, expCpuW); end
         tests++; if (incs !== expIncs || eobs !== expEob || verrs !== expVerr || validCnt !== expValid) begin fails++; $display("FAIL rand%0d_counts t=%0d got %0d %0d %0d %0d want %0d %0d %0d %0d", r, t, incs, eobs, verrs, validCnt, expIncs, expEob, expVerr, expValid); end
         tests++; if (viol !== 0 || postDma !== 0) begin fails++; $display("FAIL rand%0d_clean got viol=%0d dma=%0d want 0 0", r, viol, postDma); end
      end
   endtask
   task automatic test_reset_mid;
      for (int i = 0; i < 100; i++) ramData[i] = 8'($urandom);
      len = 100; bc = 0; XferType = 2'b01;
      @(negedge PHI2); #1;
      drive(1'b1, 1'b1);
      repeat (ARM_CYCLES + 4) begin @(negedge PHI2); #1; drive(1'b0, 1'b1); end
      @(posedge PHI2); #2;
      tests++; if ({Busy, CPURnW} !== 2'b10) begin fails++; $display("FAIL rstmid_fetch got busy,rnw=%b want 10", {Busy, CPURnW}); end
      @(negedge PHI2); #1;
      Reset = 1'b1; Length1 = 1'b1;
      @(posedge PHI2); #2;
      tests++; if ({XferEnd, SetEndOfBlock, SetVerifyErr, DecLen, CPUDOE} !== 5'b0) begin fails++; $display("FAIL rstmid_abort got %b want 00000", {XferEnd, SetEndOfBlock, SetVerifyErr, DecLen, CPUDOE}); end
      @(negedge PHI2); #1;
      Reset = 1'b0; Length1 = 1'b0;
      @(posedge PHI2); #2;
      tests++; if ({Busy, DMA, CPURnW} !== 3'b001) begin fails++; $display("FAIL rstmid_idle got %b want 001", {Busy, DMA, CPURnW}); end
      cpuData[0] = 8'h9E; cpuData[1] = 8'h61;
      model(2'b00, 2);
      run_xfer(2'b00, 2, 0, 1000);
      tests++; if (!qeq(ramW, expRamW) || endCyc !== ARM_CYCLES + 2) begin fails++; $display("FAIL rstmid_restart got %p end=%0d want %p %0d", ramW, endCyc, expRamW, ARM_CYCLES + 2); end
   endtask
   initial begin
      len = 0; bc = 0;
      for (int i = 0; i < 256; i++) begin cpuData[i] = 8'h00; ramData[i] = 8'h00; end
      test_reset;
      test_stash;
      test_fetch;
      test_swap;
      test_verify;
      test_stall;
      test_random;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
